keypad_time_entry_ctrl: RTL and testbench

- Sequences the 10-key cook-time keypad into the 4-digit BCD time register (MM:SS) of the microwave timer-entry path.
- Synchronizes and debounces raw key lines, then priority-resolves them (highest key index wins).
- Accepts exactly one digit per physical press and shifts it into the time register.
- Sits between the keypad pins and the countdown timer load port; locks out entry while the oven runs.

---
 rtl/keypad_time_entry_ctrl_if.sv | 23 ++
 rtl/keypad_time_entry_ctrl.sv | 163 ++++++++++++++++
 tb/tb_keypad_time_entry_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_time_entry_ctrl_if.sv
// Keypad-to-time-register signal bundle. The master drives the key lines and controls.
// The slave (the entry controller) returns the time register and status.
interface keypad_time_entry_ctrl_if;
  logic [9:0]  keys;
  logic        lock;
  logic        clear;
  logic [15:0] time_bcd;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [2:0]  digit_count;
  logic        time_valid;
  logic        key_held;

  modport master (
    output keys, lock, clear,
    input  time_bcd, digit, digit_valid, digit_count, time_valid, key_held
  );

  modport slave (
    input  keys, lock, clear,
    output time_bcd, digit, digit_valid, digit_count, time_valid, key_held
  );
endinterface

// File: rtl/keypad_time_entry_ctrl.sv
// Debounced 10-key cook-time entry. Each accepted press shifts one BCD digit into MM:SS.
// While lock is high, new presses are refused; a key already down is tracked until it is released.
module keypad_time_entry_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  keypad_time_entry_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            ONE_SHOT = (DEBOUNCE_CYCLES == 16'd1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    REL_DEBOUNCE
  } state_t;

  state_t        state_reg;
  logic [9:0]    sync1_reg;
  logic [9:0]    ks_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    cand_reg;
  logic          key_held_reg;
  logic [15:0]   time_bcd_reg;
  logic [3:0]    digit_reg;
  logic          digit_valid_reg;
  logic [2:0]    digit_count_reg;

  logic [3:0]    code;
  logic          any;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic [3:0]    acc_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      ks_reg    <= '0;
    end else begin
      sync1_reg <= bus.keys;
      ks_reg    <= sync1_reg;
    end
  end

  // Ascending scan so the highest pressed index is the one left in code.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ks_reg[i]) code = 4'(i);
    end
  end

  assign any     = |ks_reg;
  assign cnt_inc = cnt_reg + CNT_ONE;

  // With a one-sample debounce the press is accepted straight out of IDLE.
  always_comb begin
    accept    = 1'b0;
    acc_digit = cand_reg;
    if (state_reg == IDLE) begin
      acc_digit = code;
      accept    = ONE_SHOT && any && !bus.lock;
    end else if (state_reg == DEBOUNCE) begin
      accept = any && !bus.lock && (code == cand_reg) && (cnt_inc == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cand_reg     <= 4'd0;
      key_held_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any && !bus.lock) begin
            cand_reg <= code;
            cnt_reg  <= CNT_ONE;
            if (ONE_SHOT) begin
              state_reg    <= PRESSED;
              key_held_reg <= 1'b1;
            end else begin
              state_reg <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!any || bus.lock || (code != cand_reg)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_reg    <= PRESSED;
              key_held_reg <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!any) begin
            cnt_reg <= CNT_ONE;
            if (ONE_SHOT) begin
              state_reg    <= IDLE;
              key_held_reg <= 1'b0;
            end else begin
              state_reg <= REL_DEBOUNCE;
            end
          end
        end
        REL_DEBOUNCE: begin
          if (any) begin
            state_reg <= PRESSED;
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_reg    <= IDLE;
              key_held_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          key_held_reg <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over a coincident accept: the digit is dropped and no pulse is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_bcd_reg    <= 16'h0000;
      digit_reg       <= 4'h0;
      digit_valid_reg <= 1'b0;
      digit_count_reg <= 3'd0;
    end else if (bus.clear) begin
      time_bcd_reg    <= 16'h0000;
      digit_count_reg <= 3'd0;
      digit_valid_reg <= 1'b0;
    end else if (accept) begin
      time_bcd_reg    <= {time_bcd_reg[11:0], acc_digit};
      digit_reg       <= acc_digit;
      digit_valid_reg <= 1'b1;
      if (digit_count_reg != 3'd4) digit_count_reg <= digit_count_reg + 3'd1;
    end else begin
      digit_valid_reg <= 1'b0;
    end
  end

  assign bus.time_bcd    = time_bcd_reg;
  assign bus.digit       = digit_reg;
  assign bus.digit_valid = digit_valid_reg;
  assign bus.digit_count = digit_count_reg;
  assign bus.key_held    = key_held_reg;
  assign bus.time_valid  = (time_bcd_reg[7:4] <= 4'd5);

endmodule

// File: tb/tb_keypad_time_entry_ctrl.sv
// Directed bench for keypad_time_entry_ctrl at DEBOUNCE_CYCLES=4: a table of single presses,
// then hand-written chatter, multi-key, lock, clear-on-accept and async-reset sequences.
module tb_keypad_time_entry_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  keypad_time_entry_ctrl_if kif ();

  keypad_time_entry_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [9:0]  k;
    logic        lock;
    int          pulses;
    logic [3:0]  digit;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    logic        tv;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge; counts digit_valid pulses over n cycles.
  task automatic hold_keys(input logic [9:0] k, input int n, inout int pulses);
    kif.keys = k;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (kif.digit_valid) pulses++;
    end
  endtask

  task automatic press(input logic [9:0] k, input int hold, input int rel,
                       output int pulses, output int first_at);
    pulses   = 0;
    first_at = 0;
    kif.keys = k;
    for (int i = 1; i <= hold + rel; i++) begin
      @(posedge clk);
      #1;
      if (kif.digit_valid) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
      if (i == hold) kif.keys = '0;
    end
  endtask

  task automatic pulse_clear();
    kif.clear = 1'b1;
    @(posedge clk);
    #1;
    kif.clear = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int first_at;

    vecs[0]  = '{1'b0, 10'h080, 1'b0, 1, 4'h7, 16'h0007, 3'd1, 1'b1};
    vecs[1]  = '{1'b1, 10'h002, 1'b0, 1, 4'h1, 16'h0001, 3'd1, 1'b1};
    vecs[2]  = '{1'b0, 10'h004, 1'b0, 1, 4'h2, 16'h0012, 3'd2, 1'b1};
    vecs[3]  = '{1'b0, 10'h008, 1'b0, 1, 4'h3, 16'h0123, 3'd3, 1'b1};
    vecs[4]  = '{1'b0, 10'h001, 1'b0, 1, 4'h0, 16'h1230, 3'd4, 1'b1};
    vecs[5]  = '{1'b0, 10'h200, 1'b0, 1, 4'h9, 16'h2309, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 10'h108, 1'b0, 1, 4'h8, 16'h3098, 3'd4, 1'b0};
    vecs[7]  = '{1'b1, 10'h001, 1'b0, 1, 4'h0, 16'h0000, 3'd1, 1'b1};
    vecs[8]  = '{1'b0, 10'h040, 1'b0, 1, 4'h6, 16'h0006, 3'd2, 1'b1};
    vecs[9]  = '{1'b0, 10'h020, 1'b0, 1, 4'h5, 16'h0065, 3'd3, 1'b0};
    vecs[10] = '{1'b0, 10'h010, 1'b1, 0, 4'h5, 16'h0065, 3'd3, 1'b0};

    kif.keys  = '0;
    kif.lock  = 1'b0;
    kif.clear = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset time_bcd", 32'(kif.time_bcd), 32'h0000);
    check("reset digit", 32'(kif.digit), 32'h0);
    check("reset digit_valid", 32'(kif.digit_valid), 32'h0);
    check("reset digit_count", 32'(kif.digit_count), 32'h0);
    check("reset key_held", 32'(kif.key_held), 32'h0);
    check("reset time_valid", 32'(kif.time_valid), 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].clr) pulse_clear();
      kif.lock = vecs[v].lock;
      press(vecs[v].k, 20, 12, p, first_at);
      kif.lock = 1'b0;
      $display("[TB] vec %0d keys=%h lock=%0d pulses=%0d first=%0d bcd=%h cnt=%0d",
               v, vecs[v].k, vecs[v].lock, p, first_at, kif.time_bcd, kif.digit_count);
      check($sformatf("vec%0d pulses", v), 32'(p), 32'(vecs[v].pulses));
      check($sformatf("vec%0d digit", v), 32'(kif.digit), 32'(vecs[v].digit));
      check($sformatf("vec%0d time_bcd", v), 32'(kif.time_bcd), 32'(vecs[v].bcd));
      check($sformatf("vec%0d digit_count", v), 32'(kif.digit_count), 32'(vecs[v].cnt));
      check($sformatf("vec%0d time_valid", v), 32'(kif.time_valid), 32'(vecs[v].tv));
      if (vecs[v].pulses == 1) check($sformatf("vec%0d latency", v), 32'(first_at), 32'd6);
    end

    // Chatter on key 5 (high 2, low 1), then a clean hold.
    p = 0;
    for (int c = 0; c < 30; c++) hold_keys((c % 3 != 2) ? 10'h020 : 10'h000, 1, p);
    $display("[TB] chatter pulses=%0d", p);
    check("chatter pulses", 32'(p), 32'd0);
    p = 0;
    hold_keys(10'h020, 10, p);
    hold_keys(10'h000, 12, p);
    $display("[TB] key5 hold pulses=%0d digit=%h bcd=%h", p, kif.digit, kif.time_bcd);
    check("key5 hold pulses", 32'(p), 32'd1);
    check("key5 hold digit", 32'(kif.digit), 32'h5);
    check("key5 hold time_bcd", 32'(kif.time_bcd), 32'h0655);
    check("key5 hold digit_count", 32'(kif.digit_count), 32'd4);

    // Keys 3+8, then 8 released while 3 stays down.
    p = 0;
    hold_keys(10'h108, 10, p);
    hold_keys(10'h008, 20, p);
    hold_keys(10'h000, 12, p);
    $display("[TB] multikey pulses=%0d digit=%h bcd=%h", p, kif.digit, kif.time_bcd);
    check("multikey pulses", 32'(p), 32'd1);
    check("multikey digit", 32'(kif.digit), 32'h8);
    check("multikey time_bcd", 32'(kif.time_bcd), 32'h6558);

    // Lock raised while debouncing.
    p = 0;
    hold_keys(10'h004, 3, p);
    kif.lock = 1'b1;
    hold_keys(10'h004, 17, p);
    hold_keys(10'h000, 12, p);
    kif.lock = 1'b0;
    $display("[TB] lock-in-debounce pulses=%0d bcd=%h", p, kif.time_bcd);
    check("lock debounce pulses", 32'(p), 32'd0);
    check("lock debounce time_bcd", 32'(kif.time_bcd), 32'h6558);

    // Lock raised after the press is accepted.
    p = 0;
    hold_keys(10'h010, 8, p);
    check("lock pressed key_held", 32'(kif.key_held), 32'h1);
    kif.lock = 1'b1;
    hold_keys(10'h010, 6, p);
    hold_keys(10'h000, 12, p);
    kif.lock = 1'b0;
    $display("[TB] lock-in-pressed pulses=%0d bcd=%h", p, kif.time_bcd);
    check("lock pressed pulses", 32'(p), 32'd1);
    check("lock pressed time_bcd", 32'(kif.time_bcd), 32'h5584);
    check("lock pressed key_held after release", 32'(kif.key_held), 32'h0);

    // Clear coinciding with the accept edge of key 9.
    p = 0;
    kif.keys = 10'h200;
    for (int i = 1; i <= 24; i++) begin
      kif.clear = (i == 6);
      @(posedge clk);
      #1;
      if (kif.digit_valid) p++;
      if (i == 6) begin
        check("clear edge digit_valid", 32'(kif.digit_valid), 32'h0);
        check("clear edge time_bcd", 32'(kif.time_bcd), 32'h0000);
        check("clear edge digit_count", 32'(kif.digit_count), 32'd0);
        check("clear edge key_held", 32'(kif.key_held), 32'h1);
      end
      if (i == 12) kif.keys = '0;
    end
    kif.clear = 1'b0;
    $display("[TB] clear-on-accept pulses=%0d digit=%h bcd=%h", p, kif.digit, kif.time_bcd);
    check("clear edge pulses", 32'(p), 32'd0);
    check("clear edge digit kept", 32'(kif.digit), 32'h4);

    // Async reset while key 4 is held with 12:34 entered.
    press(10'h002, 20, 12, p, first_at);
    press(10'h004, 20, 12, p, first_at);
    press(10'h008, 20, 12, p, first_at);
    p = 0;
    hold_keys(10'h010, 8, p);
    check("pre-reset time_bcd", 32'(kif.time_bcd), 32'h1234);
    check("pre-reset key_held", 32'(kif.key_held), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    $display("[TB] async reset bcd=%h cnt=%0d held=%0d", kif.time_bcd, kif.digit_count, kif.key_held);
    check("async reset time_bcd", 32'(kif.time_bcd), 32'h0000);
    check("async reset digit", 32'(kif.digit), 32'h0);
    check("async reset digit_count", 32'(kif.digit_count), 32'd0);
    check("async reset key_held", 32'(kif.key_held), 32'h0);
    check("async reset time_valid", 32'(kif.time_valid), 32'h1);
    #2;
    rst = 1'b0;
    p = 0;
    hold_keys(10'h010, 20, p);
    hold_keys(10'h000, 12, p);
    $display("[TB] post-reset pulses=%0d digit=%h bcd=%h", p, kif.digit, kif.time_bcd);
    check("post-reset pulses", 32'(p), 32'd1);
    check("post-reset digit", 32'(kif.digit), 32'h4);
    check("post-reset time_bcd", 32'(kif.time_bcd), 32'h0004);
    check("post-reset digit_count", 32'(kif.digit_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
